// File: rtl/riscv_defines.sv
// Shared definitions for the multiplier writeback buffer.
// Holds the FIFO depth and the buffer state encoding.
package riscv_defines;

  localparam int MULT_WB_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } mult_wb_state_e;

endpackage

// File: rtl/riscv_mult_wb_buf_if.sv
// Handshake bundle between the multiplier, the writeback buffer and writeback.
// The master side drives results and writeback ready; the slave is the buffer.
interface riscv_mult_wb_buf_if;

  logic        mult_valid_i;
  logic        mult_multicycle_i;
  logic [31:0] mult_result_i;
  logic [4:0]  mult_waddr_i;
  logic        mult_ready_o;
  logic        wb_valid_o;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_waddr_o;
  logic        wb_ready_i;
  logic        flush_i;
  logic        overflow_o;

  modport master (
    output mult_valid_i, mult_multicycle_i,
    output mult_result_i, mult_waddr_i,
    output wb_ready_i, flush_i,
    input  mult_ready_o, wb_valid_o,
    input  wb_result_o, wb_waddr_o,
    input  overflow_o
  );

  modport slave (
    input  mult_valid_i, mult_multicycle_i,
    input  mult_result_i, mult_waddr_i,
    input  wb_ready_i, flush_i,
    output mult_ready_o, wb_valid_o,
    output wb_result_o, wb_waddr_o,
    output overflow_o
  );

endinterface

// File: rtl/riscv_mult_wb_buf.sv
// Two-entry multiplier result buffer in front of writeback.
// Define MULT_WB_BYPASS_EN to pass results straight through an empty buffer.
module riscv_mult_wb_buf
  import riscv_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mult_valid_i,
  input  logic        mult_multicycle_i,
  input  logic [31:0] mult_result_i,
  input  logic [4:0]  mult_waddr_i,
  output logic        mult_ready_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_result_o,
  output logic [4:0]  wb_waddr_o,
  input  logic        wb_ready_i,
  input  logic        flush_i,
  output logic        overflow_o
);

  mult_wb_state_e state_q, state_d;
  logic rptr_q, rptr_d;
  logic wptr_q, wptr_d;
  logic ovf_q, ovf_d;
  logic [31:0] data_q [MULT_WB_DEPTH];
  logic [4:0]  addr_q [MULT_WB_DEPTH];

  logic push_req, push, pop;
  logic byp, st_push, st_pop;

  assign mult_ready_o = (state_q != FULL);
  assign push_req     = mult_valid_i & ~mult_multicycle_i;
  assign push         = push_req & mult_ready_o;

`ifdef MULT_WB_BYPASS_EN
  assign byp = push & (state_q == EMPTY) & wb_ready_i;
`else
  assign byp = 1'b0;
`endif

  assign wb_valid_o  = (state_q != EMPTY) | byp;
  assign wb_result_o = byp ? mult_result_i : data_q[rptr_q];
  assign wb_waddr_o  = byp ? mult_waddr_i : addr_q[rptr_q];
  assign overflow_o  = ovf_q;

  assign pop     = wb_valid_o & wb_ready_i;
  // A bypassed result never touches storage or pointers
  assign st_push = push & ~byp;
  assign st_pop  = pop & ~byp;

  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    ovf_d   = ovf_q | (push_req & (state_q == FULL));
    if (st_push) wptr_d = ~wptr_q;
    if (st_pop)  rptr_d = ~rptr_q;
    unique case (state_q)
      EMPTY: if (st_push) state_d = ONE;
      ONE: begin
        if (st_push & ~st_pop)      state_d = FULL;
        else if (st_pop & ~st_push) state_d = EMPTY;
      end
      FULL:    if (st_pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
      rptr_d  = 1'b0;
      wptr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (st_push) begin
      data_q[wptr_q] <= mult_result_i;
      addr_q[wptr_q] <= mult_waddr_i;
    end
  end

endmodule

// File: tb/tb_riscv_mult_wb_buf.sv
// Directed scoreboard bench for the multiplier writeback buffer.
// Expected entries are queued on accepted pushes and checked on pops.
module tb_riscv_mult_wb_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_mult_wb_buf_if bif ();

  riscv_mult_wb_buf dut (
    .clk               (clk),
    .rst               (rst),
    .mult_valid_i      (bif.mult_valid_i),
    .mult_multicycle_i (bif.mult_multicycle_i),
    .mult_result_i     (bif.mult_result_i),
    .mult_waddr_i      (bif.mult_waddr_i),
    .mult_ready_o      (bif.mult_ready_o),
    .wb_valid_o        (bif.wb_valid_o),
    .wb_result_o       (bif.wb_result_o),
    .wb_waddr_o        (bif.wb_waddr_o),
    .wb_ready_i        (bif.wb_ready_i),
    .flush_i           (bif.flush_i),
    .overflow_o        (bif.overflow_o)
  );

  int tests = 0;
  int fails = 0;
  int cnt   = 0;
  bit ovf   = 1'b0;
  logic [36:0] sb [$];

  task automatic chk(string tag, logic [36:0] obs, logic [36:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, bit mc, logic [31:0] d,
                       logic [4:0] a, bit rdy, bit fl);
    bif.mult_valid_i      = v;
    bif.mult_multicycle_i = mc;
    bif.mult_result_i     = d;
    bif.mult_waddr_i      = a;
    bif.wb_ready_i        = rdy;
    bif.flush_i           = fl;
  endtask

  task automatic idle(bit rdy);
    drive(1'b0, 1'b0, 32'h0, 5'd0, rdy, 1'b0);
  endtask

  // Check outputs mid-cycle, then advance the model across the edge
  task automatic tick();
    logic [36:0] e;
    bit req, pu, po, byp;
    @(negedge clk);
    req = bif.mult_valid_i & ~bif.mult_multicycle_i;
    pu  = req && (cnt < 2);
    byp = 1'b0;
`ifdef MULT_WB_BYPASS_EN
    byp = pu && (cnt == 0) && bif.wb_ready_i;
`endif
    po  = (cnt > 0) && bif.wb_ready_i;
    chk("valid", {36'd0, bif.wb_valid_o}, {36'd0, (cnt > 0) | byp});
    chk("ready", {36'd0, bif.mult_ready_o}, {36'd0, cnt < 2});
    chk("ovf", {36'd0, bif.overflow_o}, {36'd0, ovf});
    if (byp) begin
      chk("bypass", {bif.wb_waddr_o, bif.wb_result_o},
          {bif.mult_waddr_i, bif.mult_result_i});
    end else if (po) begin
      e = sb.pop_front();
      chk("data", {bif.wb_waddr_o, bif.wb_result_o}, e);
    end
    if (pu && !byp)
      sb.push_back({bif.mult_waddr_i, bif.mult_result_i});
    if (req && cnt == 2) ovf = 1'b1;
    cnt = sb.size();
    if (bif.flush_i || rst) begin
      sb.delete();
      cnt = 0;
    end
    if (rst) ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // single push then pop
    drive(1'b1, 1'b0, 32'h0000_1234, 5'd5, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    tick();
    tick();

    // fill, overflow, drain
    drive(1'b1, 1'b0, 32'hA, 5'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hB, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hC, 5'd3, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    tick();
    idle(1'b1);
    repeat (3) tick();

    // MULH intermediate steps are never stored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'hDEAD_0000 + i, 5'd7, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'hFFFF_FFFE, 5'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h1111_1111, 5'd8, 1'b0, 1'b0);
    tick();
    idle(1'b1);
    repeat (2) tick();

    // steady push+pop in ONE with pointer wrap
    drive(1'b1, 1'b0, 32'h100, 5'd10, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h200 + i, 5'(11 + i), 1'b1, 1'b0);
      tick();
    end
    idle(1'b1);
    repeat (2) tick();

    // flush beats a same-cycle push
    drive(1'b1, 1'b0, 32'h300, 5'd20, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h301, 5'd21, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h302, 5'd22, 1'b1, 1'b1);
    tick();
    idle(1'b1);
    repeat (2) tick();

    // reset while full with overflow set
    drive(1'b1, 1'b0, 32'h400, 5'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h401, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h402, 5'd3, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(1'b1);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
